// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute-stage ALU.
//   FUNC_W  : width of the operation code
//   func_t  : operation codes (10..15 reserved, decoded as NOP)
//   state_t : issue state machine (IDLE, MUL_RUN)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        ADC = 4'd2,
        SUB = 4'd3,
        AND = 4'd4,
        OR  = 4'd5,
        XOR = 4'd6,
        SHL = 4'd7,
        SHR = 4'd8,
        MUL = 4'd9
    } func_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Issue/result bundle between the register-file side and the ALU.
//   master : drives start, func, a, b; observes result, w, busy, z, c, nf
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_if #(
    parameter int n = 8
);
    import alu_pkg::*;

    logic         start;
    func_t        func;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [n-1:0] result;
    logic         w;
    logic         busy;
    logic         z;
    logic         c;
    logic         nf;

    modport master (
        output start, func, a, b,
        input  result, w, busy, z, c, nf
    );

    modport slave (
        input  start, func, a, b,
        output result, w, busy, z, c, nf
    );

endinterface

// File: rtl/alu_mul.sv
// -----------------------------------------------------------------------------
// alu_mul
// n-step sequential shift-add multiplier producing a 2n-bit product.
// Ports:
//   clk, n_reset : clock, asynchronous active-low reset
//   i_start      : capture operands and begin (ignored while busy)
//   i_a, i_b     : multiplicand, multiplier
//   o_busy       : a multiply is in progress
//   o_done       : the current edge performs the final step
//   o_product    : product value after the current step (final when o_done)
// -----------------------------------------------------------------------------
module alu_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           i_start,
    input  logic [n-1:0]   i_a,
    input  logic [n-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*n-1:0] o_product
);

    localparam int              CNT_W = $clog2(n + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(n - 1);

    logic [2*n-1:0] r_acc;
    logic [2*n-1:0] r_mcand;
    logic [n-1:0]   r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic           r_busy;
    logic [2*n-1:0] w_acc_nxt;

    // The product is exposed combinationally so the caller can register it on
    // the same edge that performs the last step.
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_product = w_acc_nxt;
    assign o_done    = r_busy && (r_cnt == LAST);
    assign o_busy    = r_busy;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{n{1'b0}}, i_a};
                r_mplier <= i_b;
            end
        end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Execute stage behind the 32 x n register file: single-cycle logic/arith ops
// and an optional n-cycle multiply. Holds the z/c/nf status flags.
// Ports:
//   clk, n_reset : clock, asynchronous active-low reset
//   bus (slave)  : start/func/a/b in; result (w_data), w (write strobe),
//                  busy, z, c, nf out
// Configuration macro ALU_MUL_EN: when defined, MUL is implemented with the
// alu_mul sub-module; otherwise MUL decodes as NOP and busy is tied low.
// -----------------------------------------------------------------------------
module alu #(
    parameter int n = 8
) (
    input  logic  clk,
    input  logic  n_reset,
    alu_if.slave  bus
);
    import alu_pkg::*;

    state_t       r_state;
    logic [n-1:0] r_result;
    logic         r_w;
    logic         r_z;
    logic         r_c;
    logic         r_nf;

    logic         w_accept;
    logic         w_wr;
    logic [n-1:0] w_res;
    logic         w_c;
    logic [n:0]   w_sum;

    assign w_accept = bus.start && (r_state == IDLE);

    // Single-cycle datapath; w_wr marks the ops that write this cycle.
    always_comb begin
        w_wr  = 1'b1;
        w_res = r_result;
        w_c   = r_c;
        w_sum = '0;
        case (bus.func)
            ADD: begin
                w_sum = {1'b0, bus.a} + {1'b0, bus.b};
                w_res = w_sum[n-1:0];
                w_c   = w_sum[n];
            end
            ADC: begin
                w_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{n{1'b0}}, r_c};
                w_res = w_sum[n-1:0];
                w_c   = w_sum[n];
            end
            SUB: begin
                // The (n+1)-bit difference wraps negative exactly when a < b.
                w_sum = {1'b0, bus.a} - {1'b0, bus.b};
                w_res = w_sum[n-1:0];
                w_c   = w_sum[n];
            end
            AND: begin
                w_res = bus.a & bus.b;
                w_c   = 1'b0;
            end
            OR: begin
                w_res = bus.a | bus.b;
                w_c   = 1'b0;
            end
            XOR: begin
                w_res = bus.a ^ bus.b;
                w_c   = 1'b0;
            end
            SHL: begin
                w_res = {bus.a[n-2:0], 1'b0};
                w_c   = bus.a[n-1];
            end
            SHR: begin
                w_res = {1'b0, bus.a[n-1:1]};
                w_c   = bus.a[0];
            end
            default: w_wr = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic           w_mul_busy;
    logic           w_mul_done;
    logic [2*n-1:0] w_mul_prod;

    alu_mul #(.n(n)) u_mul (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_start   (w_accept && (bus.func == MUL)),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign bus.busy = w_mul_busy;
`else
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_w      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_nf     <= 1'b0;
        end else begin
            r_w <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_wr) begin
                        r_result <= w_res;
                        r_c      <= w_c;
                        r_z      <= (w_res == '0);
                        r_nf     <= w_res[n-1];
                        r_w      <= 1'b1;
                    end
`ifdef ALU_MUL_EN
                    else if (w_accept && (bus.func == MUL)) begin
                        r_state <= MUL_RUN;
                    end
`endif
                end
`ifdef ALU_MUL_EN
                MUL_RUN: begin
                    if (w_mul_done) begin
                        r_result <= w_mul_prod[n-1:0];
                        r_c      <= |w_mul_prod[2*n-1:n];
                        r_z      <= (w_mul_prod[n-1:0] == '0);
                        r_nf     <= w_mul_prod[n-1];
                        r_w      <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.w      = r_w;
    assign bus.z      = r_z;
    assign bus.c      = r_c;
    assign bus.nf     = r_nf;

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Execute stage directly downstream of the 32 x n register file.
- Takes Rd_data/Rs_data as operands, computes a result and returns it as w_data with a one-cycle write strobe w.
- Holds the processor status flags.
- Single-cycle logic/arithmetic ops, plus an n-cycle sequential shift-add multiply with a busy handshake.

Parameters:
- n, 8, datapath width; must match the register file's n.

Ports:
- clk  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- start  input  1  issue strobe; sampled on rising edge of clk
- func  input  4  operation code (alu_pkg::func_t)
- a  input  n  operand A; wired from Rd_data
- b  input  n  operand B; wired from Rs_data
- result  output  n  registered result; wired to w_data
- w  output  1  one-cycle write strobe; wired to register file w
- busy  output  1  high while a multiply is in progress
- z  output  1  zero flag
- c  output  1  carry/borrow flag
- nf  output  1  negative flag (result MSB)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (n_reset).
- Reset values: result=0, w=0, busy=0, z=0, c=0, nf=0, state=IDLE, mul counter=0. Reset mid-multiply aborts it; no w pulse is issued.
- func codes: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 MUL. Codes 10-15 are reserved and behave as NOP.
- Issue: an op is accepted only when start=1 and state=IDLE. start while busy is ignored; no queueing.
- Operand capture: a and b are captured at the accepting edge; later changes to a/b are ignored.
- Single-cycle ops:
  - Accepted at edge k; after edge k, result, z/c/nf and w=1 are valid.
  - w drops after edge k+1 unless a new op is accepted at edge k+1.
  - Back-to-back issue every cycle is legal.
- ADD: {c,result} = a+b.
- ADC: {c,result} = a+b+c_old.
- SUB: result = a-b; c=1 when a<b (borrow).
- AND/OR/XOR: c cleared.
- SHL: result = a<<1, c=a[n-1].
- SHR: result = a>>1 (logical), c=a[0].
- MUL, state machine IDLE -> MUL_RUN -> IDLE:
  - Accepted at edge k: busy=1 after edge k.
  - Each subsequent edge performs one shift-add step of the 2n-bit product.
  - After edge k+n: busy=0, w=1, result=product[n-1:0], c=|product[2n-1:n].
- Flags: z=(result==0) and nf=result[n-1] are updated with every write.
- NOP/reserved: no w; result and flags held.
- w never asserts for two consecutive cycles from a single op.
- busy and w are never high in the same cycle.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL implemented as above, with the alu_mul sub-module instantiated.
- Undefined: MUL is treated as reserved (NOP). busy is tied 0. The MUL_RUN state and the multiplier are not synthesised.

Decomposition:
- alu_pkg holds:
  - func_t enum (4-bit codes above)
  - state_t enum {IDLE, MUL_RUN}
  - FUNC_W=4 constant
- Sub-module alu_mul (parameter n): start/busy/done shift-add multiplier with 2n-bit product and $clog2(n+1) step counter. Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset: pulse n_reset low mid-operation -> result=0, w=0, busy=0, z=c=nf=0 immediately (asynchronously).
- ADD: a=8'hFF, b=8'h01 -> after one edge result=8'h00, z=1, c=1, nf=0, w high exactly one cycle.
- ADC following that ADD: a=8'h10, b=8'h20 -> result=8'h31, c=0, z=0. SUB with a=8'd5, b=8'd7 -> result=8'hFE, c=1, nf=1.
- MUL with a=8'd15, b=8'd17 -> busy high 8 cycles, then result=8'hFF, c=0, w one cycle. MUL with a=8'd20, b=8'd20 -> result=8'h90, c=1.
- start with ADD pulsed during MUL busy -> ignored; only the MUL write occurs. Reserved func=4'hC -> no w, flags unchanged.
- Integration with the register file:
  - ADD a=Rd_data, b=Rs_data into R5 -> gpr[5] updated on the w edge.
  - Write targeting R0 -> register file still reads 0.
